// File: rtl/conv_job_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_job_sequencer : drives one fixed(8.8)->float16 job at a time through the core
// Rev 1.0
// ---------------------------------------------------------------------------
module conv_job_sequencer #(
   parameter logic [7:0] IN_ADDR_LO  = 8'd0,
   parameter logic [7:0] IN_ADDR_HI  = 8'd1,
   parameter logic [7:0] OUT_ADDR_LO = 8'd2,
   parameter logic [7:0] OUT_ADDR_HI = 8'd3,
   parameter int         TIMEOUT     = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [15:0] op_data,
   output logic        op_ready,
   output logic        res_valid,
   output logic [15:0] res_data,
   output logic        res_err,
   input  logic        res_ready,
   output logic        dm_wr_en,
   output logic [7:0]  dm_addr,
   output logic [7:0]  dm_wr_data,
   input  logic [7:0]  dm_rd_data,
   output logic        core_reset,
   output logic        core_start,
   input  logic        core_ack,
   output logic        busy,
   output logic [15:0] job_count
);

   localparam int TW = $clog2(TIMEOUT) + 1;

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_CRST = 4'd1;
   localparam logic [3:0] S_WHI  = 4'd2;
   localparam logic [3:0] S_WLO  = 4'd3;
   localparam logic [3:0] S_STRT = 4'd4;
   localparam logic [3:0] S_WAIT = 4'd5;
   localparam logic [3:0] S_RHI  = 4'd6;
   localparam logic [3:0] S_RLO  = 4'd7;
   localparam logic [3:0] S_DONE = 4'd8;

   logic [3:0]    r_state;
   logic [3:0]    w_next;
   logic [15:0]   r_op;
   logic [15:0]   r_res;
   logic          r_err;
   logic [TW-1:0] r_timer;
   logic [15:0]   r_job_count;
   logic          w_timeout;

   assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (op_valid) w_next = S_CRST;
         S_CRST: w_next = S_WHI;
         S_WHI:  w_next = S_WLO;
         S_WLO:  w_next = S_STRT;
         S_STRT: w_next = S_WAIT;
         // ack takes priority over an expiring timer in the same cycle
         S_WAIT: begin
            if (core_ack)       w_next = S_RHI;
            else if (w_timeout) w_next = S_DONE;
         end
         S_RHI:  w_next = S_RLO;
         S_RLO:  w_next = S_DONE;
         S_DONE: if (res_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_op        <= 16'h0000;
         r_res       <= 16'h0000;
         r_err       <= 1'b0;
         r_timer     <= '0;
         r_job_count <= 16'h0000;
      end else begin
         case (r_state)
            S_IDLE: if (op_valid) r_op <= op_data;
            S_STRT: r_timer <= '0;
            S_WAIT: begin
               if (!core_ack) begin
                  if (w_timeout) begin
                     r_res <= 16'h0000;
                     r_err <= 1'b1;
                  end else begin
                     r_timer <= r_timer + 1'b1;
                  end
               end
            end
            S_RHI:  r_res[15:8] <= dm_rd_data;
            S_RLO:  r_res[7:0]  <= dm_rd_data;
            S_DONE: begin
               if (res_ready) begin
                  r_job_count <= r_job_count + 16'd1;
                  r_err       <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs are forced low for as long as reset is held, whatever the state.
   always_comb begin
      op_ready   = 1'b0;
      res_valid  = 1'b0;
      res_data   = 16'h0000;
      res_err    = 1'b0;
      dm_wr_en   = 1'b0;
      dm_addr    = 8'h00;
      dm_wr_data = 8'h00;
      core_reset = 1'b0;
      core_start = 1'b0;
      busy       = 1'b0;
      job_count  = 16'h0000;
      if (!reset) begin
         busy      = (r_state != S_IDLE);
         res_data  = r_res;
         res_err   = r_err;
         job_count = r_job_count;
         case (r_state)
            S_IDLE: op_ready = 1'b1;
            S_CRST: core_reset = 1'b1;
            S_WHI: begin
               dm_wr_en   = 1'b1;
               dm_addr    = IN_ADDR_HI;
               dm_wr_data = r_op[15:8];
            end
            S_WLO: begin
               dm_wr_en   = 1'b1;
               dm_addr    = IN_ADDR_LO;
               dm_wr_data = r_op[7:0];
            end
            S_STRT: core_start = 1'b1;
            S_RHI:  dm_addr = OUT_ADDR_HI;
            S_RLO:  dm_addr = OUT_ADDR_LO;
            S_DONE: res_valid = 1'b1;
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_job_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_conv_job_sequencer : scoreboard bench with a behavioural DM + conversion core
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_conv_job_sequencer;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        op_valid = 1'b0;
   logic [15:0] op_data = 16'h0000;
   logic        op_ready;
   logic        res_valid;
   logic [15:0] res_data;
   logic        res_err;
   logic        res_ready = 1'b0;
   logic        dm_wr_en;
   logic [7:0]  dm_addr;
   logic [7:0]  dm_wr_data;
   logic [7:0]  dm_rd_data;
   logic        core_reset;
   logic        core_start;
   logic        core_ack;
   logic        busy;
   logic [15:0] job_count;

   conv_job_sequencer #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
      .res_valid(res_valid), .res_data(res_data), .res_err(res_err), .res_ready(res_ready),
      .dm_wr_en(dm_wr_en), .dm_addr(dm_addr), .dm_wr_data(dm_wr_data), .dm_rd_data(dm_rd_data),
      .core_reset(core_reset), .core_start(core_start), .core_ack(core_ack),
      .busy(busy), .job_count(job_count)
   );

   always #5 clk = ~clk;

   // fixed 8.8 value x/256 expressed as float16, mantissa truncated
   function automatic logic [15:0] to_half(input logic [15:0] x);
      int v, m, p, frac;
      logic s;
      v = $signed(x);
      s = (v < 0);
      m = s ? -v : v;
      if (m == 0) return 16'h0000;
      p = 0;
      for (int i = 0; i < 17; i++) if (m >= (1 << i)) p = i;
      frac = (p >= 10) ? (m >> (p - 10)) : (m << (10 - p));
      return {s, 5'(p + 7), 10'(frac & 32'h3FF)};
   endfunction

   typedef struct {
      logic [15:0] data;
      logic        err;
      int          lat;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic expire(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
   endtask

   // ---------------- memory + core model ----------------
   logic [7:0] dm [256];
   assign dm_rd_data = dm[dm_addr];

   int   nxt_d = 0, cur_d = 0;
   bit   nxt_nack = 0, cur_nack = 0;
   bit   nxt_early = 0, cur_early = 0;
   logic model_ack = 1'b0;
   logic early = 1'b0;
   bit   pend = 0;
   int   cnt = 0;
   assign core_ack = model_ack | early;

   always @(posedge clk) begin
      if (dm_wr_en) dm[dm_addr] <= dm_wr_data;
      if (core_reset) begin
         model_ack <= 1'b0;
         pend      <= 0;
         early     <= cur_early;
      end else if (core_start) begin
         early <= 1'b0;
         if (!cur_nack) begin
            if (cur_d == 0) begin
               model_ack <= 1'b1;
               {dm[3], dm[2]} <= to_half({dm[1], dm[0]});
            end else begin
               pend <= 1;
               cnt  <= cur_d;
            end
         end
      end else if (pend) begin
         if (cnt == 1) begin
            model_ack <= 1'b1;
            {dm[3], dm[2]} <= to_half({dm[1], dm[0]});
            pend <= 0;
         end
         cnt <= cnt - 1;
      end
   end

   // ---------------- result-side host ----------------
   int rr_delay = 0;
   bit rr_noise = 0;
   initial begin
      int wcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (res_valid) begin
            res_ready = (wcnt >= rr_delay);
            wcnt++;
         end else begin
            wcnt = 0;
            res_ready = rr_noise && ($urandom_range(0, 3) == 0);
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int   cyc = 0, start_cyc = 0;
   int   n_wr = 0, n_crst = 0, n_start = 0;
   bit   m_idle = 1;
   int   m_count = 0;
   bit   vseen = 0;
   logic [16:0] hold;

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (reset) begin
         check("reset_outputs",
               {op_ready, res_valid, res_data, res_err, dm_wr_en, dm_addr, dm_wr_data,
                core_reset, core_start, busy, job_count}, 64'd0);
         q.delete();
         m_idle  = 1;
         m_count = 0;
         vseen   = 0;
      end else begin
         check("op_ready", op_ready, m_idle);
         check("busy", busy, !m_idle);
         check("job_count", job_count, m_count);
         if (core_start) start_cyc = cyc;
         if (res_valid) begin
            if (!vseen) begin
               vseen = 1;
               hold  = {res_data, res_err};
               if (q.size() == 0) begin
                  expire("unexpected_res_valid");
               end else begin
                  e = q.pop_front();
                  check("res_data", res_data, e.data);
                  check("res_err", res_err, e.err);
                  check("latency", cyc - start_cyc, e.lat);
                  check("pulses", {8'(n_wr), 8'(n_crst), 8'(n_start)}, 24'h020101);
               end
            end else begin
               check("res_hold", {res_data, res_err}, hold);
            end
            if (res_ready) begin
               m_count = (m_count + 1) & 16'hFFFF;
               m_idle  = 1;
               vseen   = 0;
            end
         end
         if (op_valid && op_ready) begin
            e.data    = nxt_nack ? 16'h0000 : to_half(op_data);
            e.err     = nxt_nack;
            e.lat     = nxt_nack ? TO + 1 : nxt_d + 4;
            q.push_back(e);
            cur_d     = nxt_d;
            cur_nack  = nxt_nack;
            cur_early = nxt_early;
            m_idle    = 0;
            n_wr      = 0;
            n_crst    = 0;
            n_start   = 0;
         end
         if (dm_wr_en) n_wr++;
         if (core_reset) n_crst++;
         if (core_start) n_start++;
      end
   end

   // ---------------- operand-side host ----------------
   task automatic send(input logic [15:0] op, input int d, input bit nack, input bit erly,
                       input bit keep);
      bit ok = 0;
      nxt_d     = d;
      nxt_nack  = nack;
      nxt_early = erly;
      op_data   = op;
      op_valid  = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (op_ready) ok = 1;
      end
      if (!ok) expire("op_accept");
      @(posedge clk);
      #1;
      if (!keep) op_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (m_idle && q.size() == 0 && !res_valid) ok = 1;
      end
      if (!ok) expire("job_drain");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      send(16'h0001, 3, 0, 0, 0);             // basic job
      wait_idle();
      rr_delay = 5;
      send(16'h8000, 2, 0, 0, 0);             // host stalls on result
      wait_idle();
      rr_delay = 0;
      send(16'h1234, 0, 1, 0, 0);             // core never acks
      wait_idle();
      send(16'h0100, TO - 1, 0, 0, 0);        // ack in final WAIT cycle
      wait_idle();
      send(16'h0003, 1, 0, 0, 1);             // back-to-back with op_valid held
      send(16'hFFFF, 0, 0, 0, 1);
      send(16'h7FFF, 2, 0, 0, 0);
      wait_idle();
      send(16'h0042, 4, 0, 1, 0);             // ack forced before WAIT
      wait_idle();

      // reset in the middle of WAIT, stale ack arrives afterwards
      send(16'h0500, 10, 0, 0, 0);
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (core_start) ok = 1;
      end
      if (!ok) expire("core_start");
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      send(16'h0030, 2, 0, 0, 0);
      wait_idle();

      rr_noise = 1;
      for (int j = 0; j < 40; j++) begin
         bit nk;
         nk = ($urandom_range(0, 7) == 0);
         rr_delay = $urandom_range(0, 3);
         send(16'($urandom), $urandom_range(0, TO - 1), nk, $urandom_range(0, 1) == 1 && !nk,
              $urandom_range(0, 1) == 1);
         if ($urandom_range(0, 2) == 0) begin
            op_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
      end
      op_valid = 1'b0;
      wait_idle();
      check("queue_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
